// File: rtl/flag_sequencer.sv
// Flag index sequencer: synchronized/debounced buttons plus slideshow, commits only on frame_start.
// Latency: raw button edge to cmd_pending = 2 + DEBOUNCE_CYCLES clocks; index update on the next frame_start.
// No backpressure: manual commands coalesce last-wins while pending; same-cycle commands resolve by priority.
module flag_sequencer #(
    parameter int IDX_W           = 7,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_zero,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_load,
    input  logic [IDX_W-1:0] load_value,
    input  logic             auto_en,
    input  logic [IDX_W-1:0] max_index,
    input  logic             frame_start,
    output logic [IDX_W-1:0] flag_index,
    output logic             index_changed,
    output logic             cmd_pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int DW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [CW-1:0]    DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    DB_ONE    = CW'(1);
    localparam logic [DW-1:0]    HOLD_LAST = DW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0]    DW_ONE    = DW'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [1:0] OP_ZERO = 2'd0;
    localparam logic [1:0] OP_NEXT = 2'd1;
    localparam logic [1:0] OP_PREV = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    // Bit order doubles as priority order: bit 0 (zero) wins.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_load, btn_prev, btn_next, btn_zero};

    logic [3:0]          bsync1_q, bsync2_q;
    logic                async1_q, async2_q;
    logic [3:0][CW-1:0]  dbc_q, dbc_d;
    logic [3:0]          deb_q, deb_d;
    logic [3:0]          rise;

    logic [0:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [IDX_W-1:0]    ld_q, ld_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                chg_q, chg_d;
    logic [DW-1:0]       dwell_q, dwell_d;

    logic                cmd_vld;
    logic [1:0]          cmd_op;
    logic [IDX_W-1:0]    load_clamped;
    logic [IDX_W-1:0]    idx_next, idx_prev;
    logic                commit;

    // Two-flop synchronizers for the raw buttons and the slideshow enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bsync1_q <= '0;
            bsync2_q <= '0;
            async1_q <= 1'b0;
            async2_q <= 1'b0;
        end else begin
            bsync1_q <= btn_raw;
            bsync2_q <= bsync1_q;
            async1_q <= auto_en;
            async2_q <= async1_q;
        end
    end

    // Debounce: count consecutive clocks the synchronized level disagrees; flip on the last one.
    always_comb begin
        dbc_d = dbc_q;
        deb_d = deb_q;
        rise  = '0;
        for (int i = 0; i < 4; i++) begin
            if (bsync2_q[i] == deb_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_LAST) begin
                deb_d[i] = bsync2_q[i];
                dbc_d[i] = '0;
                rise[i]  = bsync2_q[i];
            end else begin
                dbc_d[i] = dbc_q[i] + DB_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbc_q <= '0;
            deb_q <= '0;
        end else begin
            dbc_q <= dbc_d;
            deb_q <= deb_d;
        end
    end

    // Command decode with priority zero > next > prev > load; wrap arithmetic on current max.
    always_comb begin
        cmd_vld      = |rise;
        cmd_op       = OP_LOAD;
        if (rise[0])      cmd_op = OP_ZERO;
        else if (rise[1]) cmd_op = OP_NEXT;
        else if (rise[2]) cmd_op = OP_PREV;
        load_clamped = (load_value > max_index) ? max_index : load_value;
        idx_next     = (idx_q < max_index) ? idx_q + IDX_ONE : '0;
        idx_prev     = ((idx_q != '0) && (idx_q <= max_index)) ? idx_q - IDX_ONE : max_index;
    end

    // Sequencer: commit a pending command or auto-advance on frame_start, then latch any new command.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ld_d    = ld_q;
        idx_d   = idx_q;
        chg_d   = 1'b0;
        dwell_d = dwell_q;
        commit  = (state_q == S_PENDING) && frame_start;

        if (commit) begin
            case (op_q)
                OP_ZERO: idx_d = '0;
                OP_NEXT: idx_d = idx_next;
                OP_PREV: idx_d = idx_prev;
                default: idx_d = ld_q;
            endcase
            chg_d   = 1'b1;
            dwell_d = '0;
            state_d = S_IDLE;
        end else if ((state_q == S_IDLE) && frame_start && async2_q) begin
            if (dwell_q == HOLD_LAST) begin
                idx_d   = idx_next;
                chg_d   = 1'b1;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DW_ONE;
            end
        end

        // A command on the commit clock is held for the following frame, never applied now.
        if (cmd_vld) begin
            state_d = S_PENDING;
            op_d    = cmd_op;
            if (cmd_op == OP_LOAD) ld_d = load_clamped;
        end

        if (!async2_q) dwell_d = '0;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ZERO;
            ld_q    <= '0;
            idx_q   <= '0;
            chg_q   <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ld_q    <= ld_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
            dwell_q <= dwell_d;
        end
    end

    assign flag_index    = idx_q;
    assign index_changed = chg_q;
    assign cmd_pending   = (state_q == S_PENDING);

endmodule

// File: tb/tb_flag_sequencer.sv
// Self-checking bench for flag_sequencer: directed vectors, multi-cycle sequences, random run vs. model.
// Model checked every clock; outputs sampled 1 time unit after the rising edge.
// Inputs driven with blocking assignments right after each sampled edge.
module tb_flag_sequencer;

    localparam int IW   = 7;
    localparam int DB   = 4;
    localparam int HOLD = 3;

    logic          clk;
    logic          reset_v;
    logic [3:0]    btn_v;
    logic [IW-1:0] ld_v;
    logic          auto_v;
    logic [IW-1:0] mx_v;
    logic          fs_v;
    logic [IW-1:0] flag_index;
    logic          index_changed;
    logic          cmd_pending;

    flag_sequencer #(.IDX_W(IW), .DEBOUNCE_CYCLES(DB), .HOLD_FRAMES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset_v),
        .btn_zero     (btn_v[0]),
        .btn_next     (btn_v[1]),
        .btn_prev     (btn_v[2]),
        .btn_load     (btn_v[3]),
        .load_value   (ld_v),
        .auto_en      (auto_v),
        .max_index    (mx_v),
        .frame_start  (fs_v),
        .flag_index   (flag_index),
        .index_changed(index_changed),
        .cmd_pending  (cmd_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_idx, m_dwell, m_op, m_val;
    bit            m_pend, m_chg;
    bit [3:0]      m_deb;
    bit [4:0]      m_d1, m_d2;
    logic [DB-1:0] m_hist [4];

    task automatic model_reset();
        m_idx = 0; m_dwell = 0; m_op = 0; m_val = 0;
        m_pend = 0; m_chg = 0; m_deb = '0; m_d1 = '0; m_d2 = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
    endtask

    task automatic model_edge(bit [3:0] r, bit a, int lv, int mx, bit f);
        bit [4:0] seen;
        bit [3:0] rise;
        int nxt, prv;
        // Inputs reach the logic two clocks after they are sampled.
        seen = m_d2; m_d2 = m_d1; m_d1 = {a, r};
        rise = '0;
        // A button level is accepted once the last DB seen samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][DB-2:0], seen[i]};
            if (m_hist[i] == {DB{~m_deb[i]}}) begin
                m_deb[i] = ~m_deb[i];
                rise[i]  = m_deb[i];
            end
        end
        nxt = (m_idx < mx) ? m_idx + 1 : 0;
        prv = (m_idx >= 1 && m_idx <= mx) ? m_idx - 1 : mx;
        m_chg = 0;
        if (m_pend && f) begin
            case (m_op)
                0: m_idx = 0;
                1: m_idx = nxt;
                2: m_idx = prv;
                default: m_idx = m_val;
            endcase
            m_chg = 1; m_dwell = 0; m_pend = 0;
        end else if (!m_pend && f && seen[4]) begin
            m_dwell++;
            if (m_dwell == HOLD) begin
                m_idx = nxt; m_chg = 1; m_dwell = 0;
            end
        end
        if (!seen[4]) m_dwell = 0;
        if (rise != 0) begin
            m_pend = 1;
            m_op = rise[0] ? 0 : rise[1] ? 1 : rise[2] ? 2 : 3;
            if (m_op == 3) m_val = (lv < mx) ? lv : mx;
        end
    endtask

    // One clock: capture inputs, advance model at the edge, compare shortly after.
    task automatic step();
        bit [3:0] r;
        bit a, f, rs;
        int lv, mx;
        r = btn_v; a = auto_v; f = fs_v; lv = int'(ld_v); mx = int'(mx_v); rs = reset_v;
        @(posedge clk);
        if (rs) model_reset();
        else    model_edge(r, a, lv, mx, f);
        #1;
        check("model_idx", int'(flag_index), m_idx);
        check("model_chg", int'(index_changed), int'(m_chg));
        check("model_pend", int'(cmd_pending), int'(m_pend));
    endtask

    task automatic frame(int gap);
        repeat (gap) step();
        fs_v = 1'b1;
        step();
        fs_v = 1'b0;
    endtask

    task automatic press(int b);
        btn_v[b] = 1'b1;
        repeat (10) step();
        btn_v[b] = 1'b0;
        repeat (10) step();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int start;   // index loaded beforehand (max 7)
        int b;       // button: 0 zero, 1 next, 2 prev, 3 load
        int lv;      // load_value for the command
        int mx;      // max_index at command and commit
        int exp;     // expected committed index
    } vec_t;

    vec_t vec [10];
    int   aexp [8];

    initial begin
        bit saw;
        int since_fs;

        vec[0] = '{5, 1, 0, 5, 0};
        vec[1] = '{0, 2, 0, 5, 5};
        vec[2] = '{5, 1, 0, 3, 0};
        vec[3] = '{5, 2, 0, 3, 3};
        vec[4] = '{2, 1, 0, 5, 3};
        vec[5] = '{2, 2, 0, 5, 1};
        vec[6] = '{4, 0, 0, 5, 0};
        vec[7] = '{0, 3, 9, 5, 5};
        vec[8] = '{1, 3, 2, 5, 2};
        vec[9] = '{3, 1, 0, 3, 0};
        aexp = '{4, 4, 5, 5, 0, 0, 0, 1};

        reset_v = 1'b1; btn_v = '0; ld_v = '0; auto_v = 1'b0; mx_v = 7'd5; fs_v = 1'b0;
        model_reset();
        #1;
        check("rst_idx", int'(flag_index), 0);
        check("rst_chg", int'(index_changed), 0);
        check("rst_pend", int'(cmd_pending), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_v = 1'b0;

        // Held next button with frame_start every 20 clocks.
        btn_v[1] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            fs_v = (c == 20 || c == 40);
            step();
            fs_v = 1'b0;
            if (c == 5)  check("pend_clk5", int'(cmd_pending), 0);
            if (c == 6)  check("pend_clk6", int'(cmd_pending), 1);
            if (c == 20) begin
                check("first_idx", int'(flag_index), 1);
                check("first_chg", int'(index_changed), 1);
            end
            if (c == 21) check("chg_one_clk", int'(index_changed), 0);
            if (c == 40) check("held_no_repeat", int'(flag_index), 1);
        end
        btn_v[1] = 1'b0;
        repeat (10) step();

        // Short glitch must not produce a command.
        btn_v[1] = 1'b1;
        repeat (3) step();
        btn_v[1] = 1'b0;
        saw = 0;
        repeat (17) begin
            step();
            if (cmd_pending) saw = 1;
        end
        check("glitch_pend", int'(saw), 0);
        frame(1);
        check("glitch_idx", int'(flag_index), 1);

        // Table-driven arithmetic / wrap / clamp vectors.
        for (int k = 0; k < 10; k++) begin
            mx_v = 7'd7;
            ld_v = IW'(vec[k].start);
            press(3);
            frame(1);
            mx_v = IW'(vec[k].mx);
            ld_v = IW'(vec[k].lv);
            press(vec[k].b);
            check($sformatf("vec%0d_pend", k), int'(cmd_pending), 1);
            frame(1);
            check($sformatf("vec%0d_idx", k), int'(flag_index), vec[k].exp);
            check($sformatf("vec%0d_chg", k), int'(index_changed), 1);
        end

        // Last command wins: clamped load then prev before the frame.
        mx_v = 7'd5; ld_v = 7'd5;
        press(3);
        frame(1);
        ld_v = 7'd9;
        press(3);
        press(2);
        check("lastwins_pend", int'(cmd_pending), 1);
        frame(1);
        check("lastwins_idx", int'(flag_index), 4);

        // Slideshow from index 4, manual zero committed at the 5th frame.
        auto_v = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) press(0);
            frame(6);
            check($sformatf("auto_fs%0d", k + 1), int'(flag_index), aexp[k]);
        end
        auto_v = 1'b0;
        repeat (4) step();

        // Reset while a next command is pending.
        btn_v[1] = 1'b1;
        repeat (6) step();
        check("rst_pend_before", int'(cmd_pending), 1);
        #2;
        reset_v = 1'b1;
        model_reset();
        #1;
        check("midrst_idx", int'(flag_index), 0);
        check("midrst_pend", int'(cmd_pending), 0);
        check("midrst_chg", int'(index_changed), 0);
        btn_v = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_v = 1'b0;
        frame(3);
        check("postrst_idx", int'(flag_index), 0);
        check("postrst_chg", int'(index_changed), 0);

        // Randomized run against the model.
        since_fs = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 39) == 0) btn_v[b] = ~btn_v[b];
            if ($urandom_range(0, 299) == 0) auto_v = ~auto_v;
            if ($urandom_range(0, 199) == 0) mx_v = IW'($urandom_range(0, 9));
            ld_v = IW'($urandom_range(0, 12));
            if (since_fs >= 5 && $urandom_range(0, 5) == 0) begin
                fs_v = 1'b1;
                since_fs = 0;
            end else begin
                since_fs++;
            end
            step();
            fs_v = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
